// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared types and helpers for the round-robin encoder arbiter.
package rr_encoder_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_HOLD_DEFAULT = 8;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_encoder_arbiter_pick.sv
// Combinational round-robin pick: first set bit of mask at or after start, with wrap.
// Rotate so start is bit 0, take the lowest set bit, rotate back, or-reduce to an index.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = mask[(i + int'(start)) % N];
    end
  end

  // Scan downwards so the lowest set bit is the one left standing.
  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first    = '0;
        first[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < N; i++) begin
      pick_oh[(i + int'(start)) % N] = first[i];
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int b = 0; b < IDX_W; b++) begin
      for (int i = 0; i < N; i++) begin
        if (i[b]) pick_idx[b] = pick_idx[b] | pick_oh[i];
      end
    end
  end

  assign pick_vld = |mask;

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with ownership until release and a hold limit that forces rotation.
// Grant is registered one cycle after request; release hands over at the same edge.
module rr_encoder_arbiter
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_W    = idx_width(N),
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             hold_expired
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N-1:0]     grant_n;
  logic [IDX_W-1:0] grant_idx_n;
  logic             hold_expired_n;

  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] pick_start;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             owner_req;
  logic             force_rot;

  assign owner_next = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
  assign owner_req  = |(req & grant);

  // Masking out the owner lets one picker serve idle, release and forced rotation.
  assign pick_start = (state == GRANT) ? owner_next : ptr;

  rr_priority_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask     (req & ~grant),
    .start    (pick_start),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  assign force_rot = (MAX_HOLD != 0) && (cnt == CNT_LAST) && owner_req && pick_vld;

  always_comb begin
    state_n        = state;
    ptr_n          = ptr;
    cnt_n          = cnt;
    grant_n        = grant;
    grant_idx_n    = grant_idx;
    hold_expired_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_n     = pick_oh;
          grant_idx_n = pick_idx;
          cnt_n       = '0;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_n = owner_next;
          cnt_n = '0;
          if (pick_vld) begin
            grant_n     = pick_oh;
            grant_idx_n = pick_idx;
          end else begin
            grant_n     = '0;
            grant_idx_n = '0;
            state_n     = IDLE;
          end
        end else if (force_rot) begin
          ptr_n          = owner_next;
          cnt_n          = '0;
          grant_n        = pick_oh;
          grant_idx_n    = pick_idx;
          hold_expired_n = 1'b1;
        end else if (cnt != CNT_SAT) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      hold_expired <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      grant        <= grant_n;
      grant_valid  <= |grant_n;
      grant_idx    <= grant_idx_n;
      hold_expired <= hold_expired_n;
    end
  end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Bench for rr_encoder_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rr_encoder_arbiter;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 8;

  logic             CLK;
  logic             ASYNCRESETN;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             hold_expired;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner index (-1 = nobody), priority pointer, hold count, pulse.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_pulse;

  rr_encoder_arbiter #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .CLK          (CLK),
    .ASYNCRESETN  (ASYNCRESETN),
    .req          (req),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .hold_expired (hold_expired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int start);
    for (int k = 0; k < N; k++) begin
      if (m[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_pulse = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int nx;
    logic [N-1:0] others;
    m_pulse = 0;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = pick(r, m_ptr);
        m_cnt   = 0;
      end
    end else begin
      nx     = (m_owner + 1) % N;
      others = r & ~(N'(1) << m_owner);
      if (!r[m_owner]) begin
        m_ptr   = nx;
        m_cnt   = 0;
        m_owner = (r != 0) ? pick(r, nx) : -1;
      end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1 && others != 0) begin
        m_owner = pick(others, nx);
        m_ptr   = nx;
        m_cnt   = 0;
        m_pulse = 1;
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    check({tag, ".idx"}, 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".pulse"}, 32'(hold_expired), 32'(m_pulse));
  endtask

  // Called at posedge+1; drives req, advances the model, then compares after the edge.
  task automatic step(input logic [N-1:0] r, input string tag);
    req = r;
    model_step(r);
    @(posedge CLK);
    #1;
    compare_outputs(tag);
  endtask

  task automatic do_reset();
    ASYNCRESETN = 1'b0;
    req = '0;
    model_reset();
    @(posedge CLK);
    #1;
    compare_outputs("in_reset");
    ASYNCRESETN = 1'b1;
  endtask

  initial begin
    int hold_len;
    int pulses;
    logic [N-1:0] r;

    ASYNCRESETN = 1'b0;
    req = '0;
    model_reset();
    #1;
    compare_outputs("reset_async");

    // Idle with no requests.
    do_reset();
    for (int c = 0; c < 5; c++) step('0, "idle");

    // Single requester, then release; pointer lands on 3.
    do_reset();
    step(4'b0100, "single");
    check("single_idx", 32'(grant_idx), 32'd2);
    step(4'b0100, "single");
    step(4'b0100, "single");
    step(4'b0000, "single_rel");
    check("single_rel_grant", 32'(grant), 32'd0);
    step(4'b1111, "after_single");
    check("ptr_after_release", 32'(grant_idx), 32'd3);

    // Fairness: each owner holds two cycles then drops for one.
    do_reset();
    step(4'b1111, "fair");
    check("fair_first", 32'(grant_idx), 32'd0);
    step(4'b1111, "fair");
    for (int k = 1; k <= 4; k++) begin
      step(4'b1111 & ~(N'(1) << m_owner), "fair_rel");
      check("fair_order", 32'(grant_idx), 32'(k % N));
      check("fair_no_bubble", 32'(grant_valid), 32'd1);
      step(4'b1111, "fair");
    end

    // Hold limit with requester 3 waiting.
    do_reset();
    hold_len = 0;
    step(4'b0010, "hold");
    if (grant == 4'b0010) hold_len++;
    step(4'b0010, "hold");
    if (grant == 4'b0010) hold_len++;
    for (int c = 0; c < 20 && grant == 4'b0010; c++) begin
      step(4'b1010, "hold");
      if (grant == 4'b0010) hold_len++;
    end
    check("hold_len", 32'(hold_len), 32'(MAX_HOLD));
    check("hold_rot_grant", 32'(grant), 32'b1000);
    check("hold_rot_pulse", 32'(hold_expired), 32'd1);
    step(4'b1010, "hold_after");
    check("hold_pulse_once", 32'(hold_expired), 32'd0);
    step(4'b0010, "hold_rel3");
    check("hold_back_to_1", 32'(grant_idx), 32'd1);

    // Limit with no competitor.
    do_reset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0001, "solo");
      if (hold_expired) pulses++;
    end
    check("solo_grant", 32'(grant), 32'b0001);
    check("solo_pulses", 32'(pulses), 32'd0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(4'b0010, "mid");
    step(4'b0010, "mid");
    #3;
    ASYNCRESETN = 1'b0;
    model_reset();
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_valid", 32'(grant_valid), 32'd0);
    check("mid_rst_idx", 32'(grant_idx), 32'd0);
    #1;
    ASYNCRESETN = 1'b1;
    step(4'b0011, "post_rst");
    check("post_rst_first", 32'(grant), 32'b0001);

    // Random traffic: owners mostly hold, others toggle.
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i == m_owner) begin
          if ($urandom_range(99) < 8) r[i] = 1'b0;
        end else if ($urandom_range(99) < 20) begin
          r[i] = ~r[i];
        end
      end
      step(r, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
